mem_fill_arbiter: RTL and testbench
===================================

// Module: mem_fill_arbiter
// PURPOSE
//  Shares the single pipelined main-memory port between I-cache and D-cache miss
//  requests, and sequences each granted request as a full-block fill.
//  - Issues WORDS_PER_BLOCK consecutive word reads starting at the block-aligned base address.
//  - Counts the returned words and routes each one to the granted cache.
//  - Pulses a per-cache done signal when the block is complete.
//  Sits between the two cache controllers and the memory module.
// PARAMETERS
//  ADDR_W           16  byte-address width
//  DATA_W           16  memory word width
//  WORDS_PER_BLOCK   8  words per cache block (power of 2); byte stride per word = DATA_W/8
// PORTS
//  clk            in   1       system clock, rising edge
//  rst            in   1       asynchronous, active-high reset
//  i_req          in   1       I-cache miss request; held high until i_done
//  i_addr         in   ADDR_W  I-cache miss address (any byte within the block)
//  d_req          in   1       D-cache miss request; held high until d_done
//  d_addr         in   ADDR_W  D-cache miss address
//  mem_en         out  1       memory read issue strobe
//  mem_addr       out  ADDR_W  memory read address
//  mem_data_valid in   1       returned word valid (fixed memory latency, in order)
//  mem_data       in   DATA_W  returned word
//  fill_data      out  DATA_W  = mem_data, registered-free pass-through
//  fill_idx       out  log2(WORDS_PER_BLOCK)  word index within block of fill_data
//  i_fill_we      out  1       write fill_data into I-cache line
//  d_fill_we      out  1       write fill_data into D-cache line
//  i_done         out  1       one-cycle pulse: I block complete
//  d_done         out  1       one-cycle pulse: D block complete
//  busy           out  1       high in any state other than IDLE
//  state_out      out  2       current state encoding (debug)
// BEHAVIOUR
//  States (2-bit, flops reset to IDLE):
//  - IDLE=00, FILL_I=01, FILL_D=10, DONE=11.
//  Reset values:
//  - State IDLE; issue_cnt=0; recv_cnt=0; base=0; owner=I.
//  - All outputs 0.
//  Reset mid-fill aborts immediately:
//  - Later mem_data_valid beats are ignored, because they arrive in IDLE.
//  IDLE:
//  - Samples i_req/d_req.
//  - Only one request high: grant it.
//  - Both high: grant I (fixed priority; see CONFIGURATION).
//  - On grant: latch base = addr with low log2(WORDS_PER_BLOCK*DATA_W/8) bits zeroed.
//  - On grant: clear both counters; next state FILL_I or FILL_D.
//  FILL_x, issue side:
//  - mem_en=1 while issue_cnt<WORDS_PER_BLOCK.
//  - mem_addr = base + issue_cnt*(DATA_W/8).
//  - issue_cnt increments every cycle; one word issued per cycle, first word in the first FILL cycle.
//  FILL_x, receive side:
//  - On mem_data_valid: fill_idx=recv_cnt, x_fill_we=1 (combinational), recv_cnt++.
//  - mem_data_valid in IDLE/DONE is ignored: no we, no count.
//  Completion:
//  - A valid beat with recv_cnt==WORDS_PER_BLOCK-1 moves the FSM to DONE.
//  DONE (one cycle):
//  - x_done=1 for the owner only.
//  - Next state IDLE unconditionally.
//  Requester contract:
//  - Requester drops req no later than the cycle after x_done; IDLE re-samples then.
//  - Requests arriving or dropping during FILL/DONE do not preempt or abort the fill.
//  Arithmetic:
//  - Counters are log2(WORDS_PER_BLOCK)+1 bits; no wrap inside one fill.
//  - base + offset never carries out of the block.
//  Fill latency: WORDS_PER_BLOCK + memory latency + 1 (DONE) cycles from grant.
//  The other requester waits; no starvation bound without round-robin.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined:
//  - 1-bit last_owner flop (reset = D) decides ties when both req are high in IDLE.
//  - The requester not served last wins the tie.
//  - Single requests are granted as before.
//  ARB_ROUND_ROBIN_EN undefined:
//  - Fixed I-over-D priority; no last_owner flop.
// TESTING
//  1. rst pulse mid-FILL_I (after 3 beats) -> all outputs 0 and state 00 immediately; later valid beats produce no we.
//  2. i_req=1, i_addr=0x1236, latency 4:
//     - mem_addr 0x1230,0x1232..0x123E on 8 consecutive cycles.
//     - i_fill_we with fill_idx 0..7.
//     - i_done 1 cycle; d_* stay 0.
//  3. d_req=1, d_addr=0xFFF0 -> addresses 0xFFF0..0xFFFE with no wrap into 0x0000; d_done pulses once.
//  4. i_req and d_req rise together, no macro:
//     - FILL_I, then DONE, then FILL_D.
//     - d_req held throughout; i_done precedes d_done.
//  5. ARB_ROUND_ROBIN_EN defined, both req held continuously: grants alternate I,D,I,D over 4 fills.
//  6. d_req dropped mid-FILL_D and stray mem_data_valid in IDLE:
//     - Fill still completes all 8 beats.
//     - The IDLE beat causes no we and no count change.

Source files
------------

// File: rtl/mem_fill_arbiter_if.sv
// ---------------------------------------------------------------------------
// mem_fill_arbiter_if
//   Bundles the cache-miss request lines, the pipelined memory read port and
//   the cache fill outputs of mem_fill_arbiter.
//   master : the arbiter side (samples requests and returned data, drives the
//            memory issue port, fill write strobes, done pulses and status)
//   slave  : the environment side (cache controllers plus memory)
// Parameters
//   ADDR_W  byte-address width
//   DATA_W  memory word width
//   IDX_W   width of the word index within a block
// ---------------------------------------------------------------------------
interface mem_fill_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int IDX_W  = 3
);
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              mem_en;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_data_valid;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] fill_data;
  logic [IDX_W-1:0]  fill_idx;
  logic              i_fill_we;
  logic              d_fill_we;
  logic              i_done;
  logic              d_done;
  logic              busy;
  logic [1:0]        state_out;

  modport master (
    input  i_req, i_addr, d_req, d_addr, mem_data_valid, mem_data,
    output mem_en, mem_addr, fill_data, fill_idx, i_fill_we, d_fill_we,
           i_done, d_done, busy, state_out
  );

  modport slave (
    output i_req, i_addr, d_req, d_addr, mem_data_valid, mem_data,
    input  mem_en, mem_addr, fill_data, fill_idx, i_fill_we, d_fill_we,
           i_done, d_done, busy, state_out
  );
endinterface

// File: rtl/mem_fill_arbiter.sv
// ---------------------------------------------------------------------------
// mem_fill_arbiter
//   Shares one pipelined main-memory read port between I-cache and D-cache
//   miss requests. A granted request is served as a full-block fill:
//   WORDS_PER_BLOCK consecutive word reads from the block-aligned base, each
//   returned word routed to the granted cache with its index, followed by a
//   one-cycle done pulse to that cache.
// Ports
//   clk  system clock, rising edge
//   rst  asynchronous active-high reset (aborts any fill in progress)
//   bus  mem_fill_arbiter_if.master: requests, memory port, fill outputs,
//        done pulses, busy and state_out (IDLE=00 FILL_I=01 FILL_D=10 DONE=11)
// Configuration macro
//   ARB_ROUND_ROBIN_EN  defined: simultaneous requests go to the cache that
//                       was not served last. Undefined: I-cache always wins.
// ---------------------------------------------------------------------------
module mem_fill_arbiter #(
  parameter int ADDR_W          = 16,
  parameter int DATA_W          = 16,
  parameter int WORDS_PER_BLOCK = 8
) (
  input  logic                clk,
  input  logic                rst,
  mem_fill_arbiter_if.master  bus
);

  localparam int IDX_W       = $clog2(WORDS_PER_BLOCK);
  localparam int CNT_W       = IDX_W + 1;
  localparam int BYTE_STRIDE = DATA_W / 8;
  localparam int OFF_W       = $clog2(WORDS_PER_BLOCK * BYTE_STRIDE);
  localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((1 << OFF_W) - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(WORDS_PER_BLOCK);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WORDS_PER_BLOCK - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    FILL_I = 2'b01,
    FILL_D = 2'b10,
    DONE   = 2'b11
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [CNT_W-1:0]  issue_cnt;
  logic [CNT_W-1:0]  recv_cnt;
  logic [ADDR_W-1:0] base;
  logic              owner;       // 0 = I-cache, 1 = D-cache
  logic              any_req;
  logic              grant_d;
  logic              tie_to_d;
  logic [ADDR_W-1:0] grant_base;
  logic              in_fill;
  logic              last_beat;

  // Tie-break policy for simultaneous requests
`ifdef ARB_ROUND_ROBIN_EN
  logic last_owner;               // 0 = I served last, 1 = D served last

  // Remember who was granted most recently; reset favours I on the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_owner <= 1'b1;
    end else if ((state == IDLE) && any_req) begin
      last_owner <= grant_d;
    end
  end

  assign tie_to_d = ~last_owner;
`else
  assign tie_to_d = 1'b0;
`endif

  assign any_req    = bus.i_req | bus.d_req;
  assign grant_d    = bus.d_req & (~bus.i_req | tie_to_d);
  assign grant_base = (grant_d ? bus.d_addr : bus.i_addr) & ~OFF_MASK;
  assign in_fill    = (state == FILL_I) || (state == FILL_D);
  // The final beat of a block is the one arriving while recv_cnt holds the last index
  assign last_beat  = in_fill && bus.mem_data_valid && (recv_cnt == CNT_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (any_req) begin
          next_state = grant_d ? FILL_D : FILL_I;
        end else begin
          next_state = IDLE;
        end
      end
      FILL_I, FILL_D: begin
        if (last_beat) begin
          next_state = DONE;
        end else begin
          next_state = state;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Grant capture and issue/receive counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      issue_cnt <= '0;
      recv_cnt  <= '0;
      base      <= '0;
      owner     <= 1'b0;
    end else if (state == IDLE) begin
      if (any_req) begin
        base      <= grant_base;
        owner     <= grant_d;
        issue_cnt <= '0;
        recv_cnt  <= '0;
      end
    end else if (in_fill) begin
      // issue_cnt parks at WORDS_PER_BLOCK once every read has gone out
      if (issue_cnt < CNT_FULL) begin
        issue_cnt <= issue_cnt + CNT_W'(1);
      end
      if (bus.mem_data_valid) begin
        recv_cnt <= recv_cnt + CNT_W'(1);
      end
    end
  end

  // Output decode
  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_addr  = '0;
    bus.i_fill_we = 1'b0;
    bus.d_fill_we = 1'b0;
    bus.fill_idx  = '0;
    bus.i_done    = 1'b0;
    bus.d_done    = 1'b0;
    bus.busy      = (state != IDLE);
    bus.state_out = state;
    bus.fill_data = bus.mem_data;
    case (state)
      FILL_I, FILL_D: begin
        if (issue_cnt < CNT_FULL) begin
          bus.mem_en   = 1'b1;
          bus.mem_addr = base + (ADDR_W'(issue_cnt) * ADDR_W'(BYTE_STRIDE));
        end else begin
          bus.mem_en   = 1'b0;
        end
        if (bus.mem_data_valid) begin
          bus.fill_idx  = recv_cnt[IDX_W-1:0];
          bus.i_fill_we = (state == FILL_I);
          bus.d_fill_we = (state == FILL_D);
        end else begin
          bus.fill_idx  = '0;
        end
      end
      DONE: begin
        bus.i_done = ~owner;
        bus.d_done = owner;
      end
      default: begin
        bus.mem_en = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_fill_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_fill_arbiter
//   Directed bench for mem_fill_arbiter. A table of fill transactions is
//   applied in order; every cycle of each fill is compared against the
//   expected output word built from the table entry. Hand-written sequences
//   cover stray data beats in IDLE and reset in the middle of a fill.
//   Memory model: word at address a reads back as a ^ 16'h5A3C, returned
//   'lat' cycles after issue.
// ---------------------------------------------------------------------------
module tb_mem_fill_arbiter;

  logic clk = 1'b0;
  logic rst;

  mem_fill_arbiter_if #(.ADDR_W(16), .DATA_W(16), .IDX_W(3)) bus ();

  mem_fill_arbiter #(
    .ADDR_W(16),
    .DATA_W(16),
    .WORDS_PER_BLOCK(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        i_req;
    logic        d_req;
    logic [15:0] i_addr;
    logic [15:0] d_addr;
    int          lat;
    logic        exp_d;     // expected winner: 0 = I, 1 = D
    logic [15:0] exp_base;
    logic        hold;      // keep requests high after done
    int          drop_c;    // fill cycle at which owner drops req (-1: never)
  } fill_t;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [15:0] dfun(input logic [15:0] a);
    return a ^ 16'h5A3C;
  endfunction

  // {state, busy, mem_en, mem_addr, i_we, d_we, idx, i_done, d_done, fill_data}
  function automatic logic [42:0] pack(input logic [1:0] st, input logic bsy,
      input logic en, input logic [15:0] addr, input logic iwe, input logic dwe,
      input logic [2:0] idx, input logic idn, input logic ddn, input logic [15:0] fd);
    return {st, bsy, en, addr, iwe, dwe, idx, idn, ddn, fd};
  endfunction

  function automatic logic [42:0] act();
    return pack(bus.state_out, bus.busy, bus.mem_en, bus.mem_addr, bus.i_fill_we,
                bus.d_fill_we, bus.fill_idx, bus.i_done, bus.d_done, bus.fill_data);
  endfunction

  task automatic check(input string name, input logic [42:0] got, input logic [42:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h (st,bsy,en,addr,iwe,dwe,idx,idn,ddn,data)",
               name, got, want);
    end
  endtask

  task automatic run_fill(input fill_t f, input int tag, input int stop_c);
    logic        beat;
    logic        en;
    logic [15:0] addr;
    logic [15:0] fd;
    logic [2:0]  idx;
    logic [1:0]  st;
    logic        dn;
    int          k;
    // IDLE cycle: present the requests for sampling at its closing edge
    @(posedge clk); #1;
    bus.i_req          = f.i_req;
    bus.d_req          = f.d_req;
    bus.i_addr         = f.i_addr;
    bus.d_addr         = f.d_addr;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;
    @(negedge clk);
    check($sformatf("v%0d idle", tag), act(),
          pack(2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000));
    for (int c = 0; (c <= 8 + f.lat) && (c <= stop_c); c++) begin
      @(posedge clk); #1;
      if (c == f.drop_c) begin
        if (f.exp_d) bus.d_req = 1'b0;
        else         bus.i_req = 1'b0;
      end
      k    = c - f.lat;
      beat = (c >= f.lat) && (c < f.lat + 8);
      fd   = beat ? dfun(f.exp_base + 16'(2 * k)) : 16'h0000;
      bus.mem_data_valid = beat;
      bus.mem_data       = fd;
      @(negedge clk);
      en   = (c < 8);
      addr = en ? (f.exp_base + 16'(2 * c)) : 16'h0000;
      idx  = beat ? 3'(k) : 3'd0;
      dn   = (c == 8 + f.lat);
      st   = dn ? 2'b11 : (f.exp_d ? 2'b10 : 2'b01);
      check($sformatf("v%0d c%0d", tag, c), act(),
            pack(st, 1'b1, en, addr, beat & ~f.exp_d, beat & f.exp_d, idx,
                 dn & ~f.exp_d, dn & f.exp_d, fd));
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;
    if (!f.hold) begin
      if (f.exp_d) bus.d_req = 1'b0;
      else         bus.i_req = 1'b0;
    end
  endtask

  fill_t tbl[11];
  fill_t f;

  initial begin
    // Single I fill, unaligned address, latency 4
    tbl[0]  = '{1'b1, 1'b0, 16'h1236, 16'h0000, 4, 1'b0, 16'h1230, 1'b0, -1};
    // D fill at the top block of the address space
    tbl[1]  = '{1'b0, 1'b1, 16'h0000, 16'hFFF0, 2, 1'b1, 16'hFFF0, 1'b0, -1};
    // Latency 1, last byte of a block
    tbl[2]  = '{1'b1, 1'b0, 16'h0ABF, 16'h0000, 1, 1'b0, 16'h0AB0, 1'b0, -1};
    // Simultaneous requests: I first, D held and served next
    tbl[3]  = '{1'b1, 1'b1, 16'h2008, 16'h300F, 3, 1'b0, 16'h2000, 1'b0, -1};
    tbl[4]  = '{1'b0, 1'b1, 16'h2008, 16'h300F, 3, 1'b1, 16'h3000, 1'b0, -1};
    // Both requests held continuously over four fills
`ifdef ARB_ROUND_ROBIN_EN
    tbl[5]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b1, -1};
    tbl[6]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b1, 16'h5550, 1'b1, -1};
    tbl[7]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b1, -1};
    tbl[8]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b1, 16'h5550, 1'b0, -1};
`else
    tbl[5]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b1, -1};
    tbl[6]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b1, -1};
    tbl[7]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b1, -1};
    tbl[8]  = '{1'b1, 1'b1, 16'h4444, 16'h5555, 2, 1'b0, 16'h4440, 1'b0, -1};
`endif
    // D request dropped mid-fill; the fill must still complete
    tbl[9]  = '{1'b0, 1'b1, 16'h0000, 16'h7A5E, 5, 1'b1, 16'h7A50, 1'b0, 3};
    // Long latency, top block via I
    tbl[10] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 6, 1'b0, 16'hFFF0, 1'b0, -1};

    rst                = 1'b1;
    bus.i_req          = 1'b0;
    bus.d_req          = 1'b0;
    bus.i_addr         = 16'h0000;
    bus.d_addr         = 16'h0000;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;

    @(negedge clk);
    check("reset", act(),
          pack(2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000));
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      run_fill(tbl[i], i, 1000);
    end
    bus.i_req = 1'b0;
    bus.d_req = 1'b0;

    // Stray beats in IDLE: no write strobes, no state change
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = 16'hBEE0 + 16'(s);
      @(negedge clk);
      check($sformatf("stray%0d", s), act(),
            pack(2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
                 16'hBEE0 + 16'(s)));
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;

    // Following fill must index from 0 and finish after exactly 8 beats
    f = '{1'b0, 1'b1, 16'h0000, 16'h0123, 2, 1'b1, 16'h0120, 1'b0, -1};
    run_fill(f, 20, 1000);

    // Reset after three beats of an I fill
    f = '{1'b1, 1'b0, 16'h0046, 16'h0000, 2, 1'b0, 16'h0040, 1'b1, -1};
    run_fill(f, 30, 4);
    @(posedge clk); #1;
    bus.mem_data_valid = 1'b1;
    bus.mem_data       = dfun(16'h0046);
    #2;
    rst                = 1'b1;
    bus.i_req          = 1'b0;
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;
    #1;
    check("rst mid-fill", act(),
          pack(2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 16'h0000));
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      bus.mem_data_valid = 1'b1;
      bus.mem_data       = dfun(16'h0048 + 16'(2 * s));
      @(negedge clk);
      check($sformatf("post-rst beat%0d", s), act(),
            pack(2'b00, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0,
                 dfun(16'h0048 + 16'(2 * s))));
    end
    bus.mem_data_valid = 1'b0;
    bus.mem_data       = 16'h0000;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
